gtfraw_vnc_lat_run_ctrl: RTL and testbench
==========================================

Name: gtfraw_vnc_lat_run_ctrl

Overview:
Run sequencer for the latency monitor in the axi_clk domain. On one start pulse it clears the monitor, arms it for N packets, waits for full or a timeout, then drains every stored record with pop / time_rdy handshakes. While draining it computes per-record latency, min, max, sum and count, so software reads one summary instead of popping records over JTAG-AXI. It sits between the monitor PIF control/status signals and a small software-visible control/status set.

Parameters:
TIMER_WIDTH, 16, width of tx/rx timestamps and delta
RAM_ADDR_WIDTH, 12, monitor record address width; datav is RAM_ADDR_WIDTH+1 bits
CLR_CYCLES, 8, cycles lm_clear is held high
TMO_WIDTH, 32, width of timeout counters

Ports:
axi_clk  in  1  single clock for the block
axi_rstn  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a run
abort  in  1  one-cycle pulse; terminates any run
cfg_pkt_cnt  in  32  packets to collect
cfg_collect_tmo  in  TMO_WIDTH  max cycles in COLLECT; 0 = no timeout
cfg_pop_tmo  in  16  max cycles waiting for lm_time_rdy
lm_go  out  1  arm the monitor
lm_pop  out  1  one-cycle pop request
lm_clear  out  1  monitor pointer reset
lm_lat_pkt_cnt  out  32  latched cfg_pkt_cnt
lm_full  in  1  monitor full
lm_datav  in  RAM_ADDR_WIDTH+1  stored record count
lm_time_rdy  in  1  one-cycle pulse; popped record is valid
lm_snd_time  in  TIMER_WIDTH  popped tx timestamp
lm_rcv_time  in  TIMER_WIDTH  popped rx timestamp
busy  out  1  state is not IDLE or DONE
done  out  1  level; run finished; cleared by the next start
err  out  3  bit0 collect timeout, bit1 pop timeout, bit2 zero pkt count
res_cnt  out  32  records drained
res_sum  out  32  saturating sum of deltas
res_min  out  TIMER_WIDTH  minimum delta
res_max  out  TIMER_WIDTH  maximum delta

Behaviour:
- Reset values: all outputs 0, except res_min = all-ones. State = IDLE.
- States: IDLE, CLEAR, ARM, COLLECT, DRAIN_REQ, DRAIN_WAIT, DONE.
- IDLE/DONE + start:
  - Latch cfg_pkt_cnt into lm_lat_pkt_cnt.
  - Clear res_*, err and done; set res_min to all-ones.
  - If cfg_pkt_cnt == 0: set err[2], go to DONE (done = 1 next cycle).
  - Otherwise go to CLEAR.
- start while busy is ignored.
- CLEAR: lm_clear = 1 for exactly CLR_CYCLES cycles, lm_go = 0, then ARM.
- ARM: one cycle with lm_clear = 0, then COLLECT. lm_go = 1 from ARM entry through COLLECT.
- COLLECT:
  - Wait for lm_full = 1, then lm_go <= 0 and go to DRAIN_REQ.
  - Collect counter increments every cycle. If cfg_collect_tmo != 0 and the count reaches cfg_collect_tmo: set err[0], lm_go <= 0, go to DRAIN_REQ (partial drain).
- DRAIN_REQ:
  - If lm_datav == 0: go to DONE.
  - Else lm_pop = 1 for one cycle, go to DRAIN_WAIT, reset pop counter.
- DRAIN_WAIT:
  - On lm_time_rdy:
    - delta = lm_rcv_time - lm_snd_time, modulo 2^TIMER_WIDTH (wrap-around handled).
    - res_cnt += 1.
    - res_sum += zero-extended delta, saturating at 0xFFFF_FFFF.
    - res_min = min(res_min, delta); res_max = max(res_max, delta).
    - Return to DRAIN_REQ.
  - Minimum pop-to-pop spacing is 2 cycles. lm_datav is sampled in DRAIN_REQ only.
  - If the pop counter reaches cfg_pop_tmo before lm_time_rdy: set err[1], go to DONE.
- DONE: done = 1, busy = 0. Outputs hold until the next start.
- lm_time_rdy outside DRAIN_WAIT is ignored.
- abort in any state:
  - Next cycle: lm_go = 0, lm_pop = 0, lm_clear = 0, state = IDLE, done = 0.
  - res_* and err keep their values.
  - abort and start in the same cycle: abort wins.
- Asynchronous reset mid-run: all outputs return to reset values immediately.

Decomposition:
- Package gtfraw_vnc_lat_pkg holds:
  - state enum lat_run_state_t;
  - ERR_COLLECT_TMO, ERR_POP_TMO and ERR_ZERO_CNT bit indices;
  - a res_t struct for cnt, sum, min and max.
- One sub-module, gtfraw_vnc_lat_stats: delta subtraction, saturating accumulate and min/max. Inputs: clear, valid, snd, rcv. Outputs: the four results.
- The FSM and timers stay in the top module.

Test Plan:
- cfg_pkt_cnt = 4; model loads deltas 100, 250, 90, 300, then full with datav = 4 -> lm_clear high 8 cycles, 4 pops; res_cnt = 4, sum = 740, min = 90, max = 300, done = 1, err = 0.
- snd = 0xFFF0, rcv = 0x0010 (16-bit) -> delta = 0x0020; min = max = 32.
- cfg_pkt_cnt = 0 + start -> err = 3'b100, done = 1, lm_go never asserted.
- cfg_collect_tmo = 50, lm_full never rises, datav = 2 -> err[0] set, lm_go drops at cycle 50, 2 records drained, done.
- cfg_pop_tmo = 10, model withholds time_rdy -> err[1] set after 10 cycles, res_cnt = 0, done.
- abort during COLLECT, with start in the same cycle -> lm_go = 0 next cycle, state IDLE, busy = 0, done = 0; a later start runs normally.

Source files
------------

// File: rtl/gtfraw_vnc_lat_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// gtfraw_vnc_lat_pkg : shared types for the latency-monitor run sequencer
// Rev 1.0
// ------------------------------------------------------------------
package gtfraw_vnc_lat_pkg;

  localparam int LAT_TIMER_W = 16;
  localparam int LAT_RES_W   = 32;

  localparam int ERR_COLLECT_TMO = 0;
  localparam int ERR_POP_TMO     = 1;
  localparam int ERR_ZERO_CNT    = 2;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CLEAR      = 3'd1,
    ST_ARM        = 3'd2,
    ST_COLLECT    = 3'd3,
    ST_DRAIN_REQ  = 3'd4,
    ST_DRAIN_WAIT = 3'd5,
    ST_DONE       = 3'd6
  } lat_run_state_t;

  typedef struct packed {
    logic [LAT_RES_W-1:0]   cnt;
    logic [LAT_RES_W-1:0]   sum;
    logic [LAT_TIMER_W-1:0] dmin;
    logic [LAT_TIMER_W-1:0] dmax;
  } res_t;

endpackage
`default_nettype wire

// File: rtl/gtfraw_vnc_lat_stats.sv
`default_nettype none
// ------------------------------------------------------------------
// gtfraw_vnc_lat_stats : per-record delta, saturating sum, count, min/max
// Rev 1.0
// ------------------------------------------------------------------
module gtfraw_vnc_lat_stats
  import gtfraw_vnc_lat_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   valid,
  input  logic [LAT_TIMER_W-1:0] snd,
  input  logic [LAT_TIMER_W-1:0] rcv,
  output logic [LAT_RES_W-1:0]   res_cnt,
  output logic [LAT_RES_W-1:0]   res_sum,
  output logic [LAT_TIMER_W-1:0] res_min,
  output logic [LAT_TIMER_W-1:0] res_max
);

  localparam res_t RES_INIT = '{cnt: '0, sum: '0, dmin: '1, dmax: '0};

  res_t                   res_q;
  res_t                   res_d;
  logic [LAT_TIMER_W-1:0] delta;
  logic [LAT_RES_W:0]     sum_ext;

  always_comb begin
    // Unsigned subtraction wraps naturally across timer roll-over.
    delta   = rcv - snd;
    sum_ext = {1'b0, res_q.sum} + {{(LAT_RES_W + 1 - LAT_TIMER_W){1'b0}}, delta};
    res_d   = res_q;
    if (clear) begin
      res_d = RES_INIT;
    end else if (valid) begin
      res_d.cnt = res_q.cnt + LAT_RES_W'(1);
      res_d.sum = sum_ext[LAT_RES_W] ? '1 : sum_ext[LAT_RES_W-1:0];
      if (delta < res_q.dmin) res_d.dmin = delta;
      if (delta > res_q.dmax) res_d.dmax = delta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_q <= RES_INIT;
    else        res_q <= res_d;
  end

  assign res_cnt = res_q.cnt;
  assign res_sum = res_q.sum;
  assign res_min = res_q.dmin;
  assign res_max = res_q.dmax;

endmodule
`default_nettype wire

// File: rtl/gtfraw_vnc_lat_run_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// gtfraw_vnc_lat_run_ctrl : clear/arm/collect/drain sequencer for the latency monitor
// Rev 1.0
// ------------------------------------------------------------------
module gtfraw_vnc_lat_run_ctrl
  import gtfraw_vnc_lat_pkg::*;
#(
  parameter int TIMER_WIDTH    = LAT_TIMER_W,
  parameter int RAM_ADDR_WIDTH = 12,
  parameter int CLR_CYCLES     = 8,
  parameter int TMO_WIDTH      = 32
) (
  input  logic                    axi_clk,
  input  logic                    axi_rstn,
  input  logic                    start,
  input  logic                    abort,
  input  logic [31:0]             cfg_pkt_cnt,
  input  logic [TMO_WIDTH-1:0]    cfg_collect_tmo,
  input  logic [15:0]             cfg_pop_tmo,
  output logic                    lm_go,
  output logic                    lm_pop,
  output logic                    lm_clear,
  output logic [31:0]             lm_lat_pkt_cnt,
  input  logic                    lm_full,
  input  logic [RAM_ADDR_WIDTH:0] lm_datav,
  input  logic                    lm_time_rdy,
  input  logic [TIMER_WIDTH-1:0]  lm_snd_time,
  input  logic [TIMER_WIDTH-1:0]  lm_rcv_time,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              err,
  output logic [31:0]             res_cnt,
  output logic [31:0]             res_sum,
  output logic [TIMER_WIDTH-1:0]  res_min,
  output logic [TIMER_WIDTH-1:0]  res_max
);

  localparam int                   CLR_CNT_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_CNT_W-1:0] CLR_LAST  = CLR_CNT_W'(CLR_CYCLES - 1);

  lat_run_state_t       state_q, state_d;
  logic [CLR_CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [TMO_WIDTH-1:0] col_cnt_q, col_cnt_d, col_cnt_inc;
  logic [15:0]          pop_cnt_q, pop_cnt_d, pop_cnt_inc;
  logic [31:0]          lat_pkt_cnt_q, lat_pkt_cnt_d;
  logic [2:0]           err_q, err_d;
  logic                 start_ok;
  logic                 col_tmo_hit;
  logic                 pop_tmo_hit;
  logic                 stats_valid;

  always_comb begin
    start_ok    = start && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    col_cnt_inc = col_cnt_q + TMO_WIDTH'(1);
    pop_cnt_inc = pop_cnt_q + 16'd1;
    // A zero collect timeout means wait for full indefinitely.
    col_tmo_hit = (cfg_collect_tmo != '0) && (col_cnt_inc == cfg_collect_tmo);
    pop_tmo_hit = (pop_cnt_inc == cfg_pop_tmo);
    stats_valid = (state_q == ST_DRAIN_WAIT) && lm_time_rdy && !abort;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start) state_d = (cfg_pkt_cnt == '0) ? ST_DONE : ST_CLEAR;
        ST_CLEAR:         if (clr_cnt_q == CLR_LAST) state_d = ST_ARM;
        ST_ARM:           state_d = ST_COLLECT;
        ST_COLLECT:       if (lm_full || col_tmo_hit) state_d = ST_DRAIN_REQ;
        ST_DRAIN_REQ:     state_d = (lm_datav == '0) ? ST_DONE : ST_DRAIN_WAIT;
        ST_DRAIN_WAIT: begin
          if (lm_time_rdy)      state_d = ST_DRAIN_REQ;
          else if (pop_tmo_hit) state_d = ST_DONE;
        end
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    clr_cnt_d     = (state_q == ST_CLEAR)      ? clr_cnt_q + CLR_CNT_W'(1) : '0;
    col_cnt_d     = (state_q == ST_COLLECT)    ? col_cnt_inc : '0;
    pop_cnt_d     = (state_q == ST_DRAIN_WAIT) ? pop_cnt_inc : '0;
    lat_pkt_cnt_d = start_ok ? cfg_pkt_cnt : lat_pkt_cnt_q;
    err_d         = err_q;
    if (start_ok) begin
      err_d               = '0;
      err_d[ERR_ZERO_CNT] = (cfg_pkt_cnt == '0);
    end else if (!abort) begin
      // Full wins over a coincident collect timeout.
      if ((state_q == ST_COLLECT) && !lm_full && col_tmo_hit)
        err_d[ERR_COLLECT_TMO] = 1'b1;
      if ((state_q == ST_DRAIN_WAIT) && !lm_time_rdy && pop_tmo_hit)
        err_d[ERR_POP_TMO] = 1'b1;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q       <= ST_IDLE;
      clr_cnt_q     <= '0;
      col_cnt_q     <= '0;
      pop_cnt_q     <= '0;
      lat_pkt_cnt_q <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      col_cnt_q     <= col_cnt_d;
      pop_cnt_q     <= pop_cnt_d;
      lat_pkt_cnt_q <= lat_pkt_cnt_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    lm_clear = (state_q == ST_CLEAR);
    lm_go    = (state_q == ST_ARM) || (state_q == ST_COLLECT);
    lm_pop   = (state_q == ST_DRAIN_REQ) && (lm_datav != '0);
    done     = (state_q == ST_DONE);
    busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  end

  assign err            = err_q;
  assign lm_lat_pkt_cnt = lat_pkt_cnt_q;

  gtfraw_vnc_lat_stats u_stats (
    .clk     (axi_clk),
    .rst_n   (axi_rstn),
    .clear   (start_ok),
    .valid   (stats_valid),
    .snd     (lm_snd_time),
    .rcv     (lm_rcv_time),
    .res_cnt (res_cnt),
    .res_sum (res_sum),
    .res_min (res_min),
    .res_max (res_max)
  );

endmodule
`default_nettype wire

// File: tb/tb_gtfraw_vnc_lat_run_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_gtfraw_vnc_lat_run_ctrl : directed bench with a monitor stand-in and result model
// Rev 1.0
// ------------------------------------------------------------------
module tb_gtfraw_vnc_lat_run_ctrl;

  localparam int TW = 16;
  localparam int AW = 12;

  logic          axi_clk         = 1'b0;
  logic          axi_rstn        = 1'b0;
  logic          start           = 1'b0;
  logic          abort           = 1'b0;
  logic [31:0]   cfg_pkt_cnt     = '0;
  logic [31:0]   cfg_collect_tmo = '0;
  logic [15:0]   cfg_pop_tmo     = 16'd100;
  logic          lm_full         = 1'b0;
  logic [AW:0]   lm_datav        = '0;
  logic          lm_time_rdy     = 1'b0;
  logic [TW-1:0] lm_snd_time     = '0;
  logic [TW-1:0] lm_rcv_time     = '0;
  logic          lm_go, lm_pop, lm_clear, busy, done;
  logic [31:0]   lm_lat_pkt_cnt, res_cnt, res_sum;
  logic [2:0]    err;
  logic [TW-1:0] res_min, res_max;

  int     checks = 0;
  int     errors = 0;
  longint m_cnt = 0, m_sum = 0, m_min = 65535, m_max = 0;
  int     rdy_lat  = 1;
  bit     withhold = 1'b0;
  bit     chk_en   = 1'b0;
  logic [15:0] q_snd[$];
  logic [15:0] q_rcv[$];
  logic [15:0] mon_s, mon_r;
  int     clr_cycles = 0, go_cycles = 0, pops = 0, quiet_busy = 0;
  bit     go_ever = 1'b0;

  gtfraw_vnc_lat_run_ctrl dut (
    .axi_clk         (axi_clk),
    .axi_rstn        (axi_rstn),
    .start           (start),
    .abort           (abort),
    .cfg_pkt_cnt     (cfg_pkt_cnt),
    .cfg_collect_tmo (cfg_collect_tmo),
    .cfg_pop_tmo     (cfg_pop_tmo),
    .lm_go           (lm_go),
    .lm_pop          (lm_pop),
    .lm_clear        (lm_clear),
    .lm_lat_pkt_cnt  (lm_lat_pkt_cnt),
    .lm_full         (lm_full),
    .lm_datav        (lm_datav),
    .lm_time_rdy     (lm_time_rdy),
    .lm_snd_time     (lm_snd_time),
    .lm_rcv_time     (lm_rcv_time),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .res_cnt         (res_cnt),
    .res_sum         (res_sum),
    .res_min         (res_min),
    .res_max         (res_max)
  );

  initial forever #5 axi_clk = ~axi_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic m_clear();
    m_cnt = 0; m_sum = 0; m_min = 65535; m_max = 0;
  endtask

  // Expected result of one drained record, straight from the latency definition.
  task automatic m_add(input logic [15:0] s, input logic [15:0] r);
    longint d;
    d = (longint'(r) - longint'(s) + 65536) % 65536;
    m_cnt = m_cnt + 1;
    m_sum = (m_sum + d > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_sum + d;
    if (d < m_min) m_min = d;
    if (d > m_max) m_max = d;
  endtask

  task automatic tick();
    @(posedge axi_clk); #1;
  endtask

  task automatic push_rec(input logic [15:0] s, input logic [15:0] r);
    q_snd.push_back(s);
    q_rcv.push_back(r);
    lm_datav = (AW+1)'(q_snd.size());
  endtask

  task automatic pulse_start(input logic [31:0] pkt);
    cfg_pkt_cnt = pkt;
    start       = 1'b1;
    @(posedge axi_clk);
    m_clear();
    clr_cycles = 0; go_cycles = 0; pops = 0; quiet_busy = 0; go_ever = 1'b0;
    #1 start = 1'b0;
  endtask

  task automatic wait_go(input int max_cyc);
    int n = 0;
    while (lm_go !== 1'b1 && n < max_cyc) begin @(negedge axi_clk); n++; end
    check("wait_go_bound", {63'd0, lm_go}, 64'd1);
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (done !== 1'b1 && n < max_cyc) begin @(negedge axi_clk); n++; end
    check("wait_done_bound", {63'd0, done}, 64'd1);
  endtask

  // Monitor stand-in: answers each pop with the next stored record after rdy_lat cycles.
  initial begin
    forever begin
      @(negedge axi_clk);
      if (lm_pop === 1'b1 && !withhold && q_snd.size() > 0) begin
        repeat (rdy_lat) @(posedge axi_clk);
        #1;
        mon_s       = q_snd.pop_front();
        mon_r       = q_rcv.pop_front();
        lm_snd_time = mon_s;
        lm_rcv_time = mon_r;
        lm_time_rdy = 1'b1;
        lm_datav    = (AW+1)'(q_snd.size());
        @(posedge axi_clk);
        m_add(mon_s, mon_r);
        #1 lm_time_rdy = 1'b0;
      end
    end
  end

  always @(negedge axi_clk) begin
    if (chk_en) begin
      check("res_cnt", {32'd0, res_cnt}, m_cnt);
      check("res_sum", {32'd0, res_sum}, m_sum);
      check("res_min", {48'd0, res_min}, m_min);
      check("res_max", {48'd0, res_max}, m_max);
      check("go_clear_excl", {63'd0, lm_go & lm_clear}, 64'd0);
      check("busy_done_excl", {63'd0, busy & done}, 64'd0);
    end
  end

  always @(negedge axi_clk) begin
    clr_cycles += int'(lm_clear);
    go_cycles  += int'(lm_go);
    pops       += int'(lm_pop);
    if (lm_go) go_ever = 1'b1;
    if (busy && !lm_pop && !lm_go && !lm_clear) quiet_busy++;
  end

  initial begin
    repeat (3) @(negedge axi_clk);
    check("rst_lm_go",    {63'd0, lm_go},    64'd0);
    check("rst_lm_pop",   {63'd0, lm_pop},   64'd0);
    check("rst_lm_clear", {63'd0, lm_clear}, 64'd0);
    check("rst_busy",     {63'd0, busy},     64'd0);
    check("rst_done",     {63'd0, done},     64'd0);
    check("rst_err",      {61'd0, err},      64'd0);
    check("rst_lat_pkt",  {32'd0, lm_lat_pkt_cnt}, 64'd0);
    check("rst_res_cnt",  {32'd0, res_cnt},  64'd0);
    check("rst_res_sum",  {32'd0, res_sum},  64'd0);
    check("rst_res_min",  {48'd0, res_min},  64'hFFFF);
    check("rst_res_max",  {48'd0, res_max},  64'd0);
    tick();
    axi_rstn = 1'b1;
    chk_en   = 1'b1;
    tick();

    // Four records, deltas 100/250/90/300.
    rdy_lat = 1;
    push_rec(16'd1000, 16'd1100); push_rec(16'd2000, 16'd2250);
    push_rec(16'd3000, 16'd3090); push_rec(16'd4000, 16'd4300);
    pulse_start(32'd4);
    wait_go(40);
    repeat (4) tick();
    lm_full = 1'b1;
    wait_done(200);
    tick();
    lm_full = 1'b0;
    check("t1_err",        {61'd0, err},        64'd0);
    check("t1_busy",       {63'd0, busy},       64'd0);
    check("t1_clr_cycles", 64'(clr_cycles),     64'd8);
    check("t1_pops",       64'(pops),           64'd4);
    check("t1_wait_cycles", 64'(quiet_busy),    64'd5);
    check("t1_lat_pkt",    {32'd0, lm_lat_pkt_cnt}, 64'd4);
    check("t1_cnt",        {32'd0, res_cnt},    64'd4);
    check("t1_sum",        {32'd0, res_sum},    64'd740);
    check("t1_min",        {48'd0, res_min},    64'd90);
    check("t1_max",        {48'd0, res_max},    64'd300);

    // Stray time_rdy while DONE must not touch the results.
    lm_snd_time = 16'd0; lm_rcv_time = 16'd5; lm_time_rdy = 1'b1;
    tick();
    lm_time_rdy = 1'b0;
    tick();
    check("stray_rdy_cnt", {32'd0, res_cnt}, 64'd4);

    // Timestamp wrap-around.
    rdy_lat = 3;
    push_rec(16'hFFF0, 16'h0010);
    pulse_start(32'd1);
    wait_go(40);
    tick();
    lm_full = 1'b1;
    wait_done(200);
    tick();
    lm_full = 1'b0;
    check("t2_min", {48'd0, res_min}, 64'd32);
    check("t2_max", {48'd0, res_max}, 64'd32);
    check("t2_sum", {32'd0, res_sum}, 64'd32);
    check("t2_err", {61'd0, err},     64'd0);
    check("t2_wait_cycles", 64'(quiet_busy), 64'd4);

    // Zero packet count.
    pulse_start(32'd0);
    @(negedge axi_clk);
    check("t3_done", {63'd0, done}, 64'd1);
    check("t3_err",  {61'd0, err},  64'd4);
    check("t3_busy", {63'd0, busy}, 64'd0);
    repeat (5) tick();
    check("t3_go_never", {63'd0, go_ever}, 64'd0);

    // Collect timeout with a partial drain of two records.
    cfg_collect_tmo = 32'd50;
    rdy_lat = 2;
    push_rec(16'd10, 16'd15); push_rec(16'd20, 16'd27);
    pulse_start(32'd9);
    wait_done(300);
    tick();
    cfg_collect_tmo = 32'd0;
    check("t4_err",       {61'd0, err},     64'd1);
    check("t4_go_cycles", 64'(go_cycles),   64'd51);
    check("t4_pops",      64'(pops),        64'd2);
    check("t4_wait_cycles", 64'(quiet_busy), 64'd5);
    check("t4_cnt",       {32'd0, res_cnt}, 64'd2);
    check("t4_sum",       {32'd0, res_sum}, 64'd12);

    // Pop timeout: the record is never delivered.
    cfg_pop_tmo = 16'd10;
    withhold = 1'b1;
    lm_full  = 1'b1;
    push_rec(16'd1, 16'd2);
    pulse_start(32'd1);
    wait_done(200);
    tick();
    check("t5_err",         {61'd0, err},     64'd2);
    check("t5_wait_cycles", 64'(quiet_busy),  64'd10);
    check("t5_pops",        64'(pops),        64'd1);
    check("t5_cnt",         {32'd0, res_cnt}, 64'd0);
    withhold = 1'b0;
    lm_full  = 1'b0;
    q_snd.delete(); q_rcv.delete();
    lm_datav = '0;
    cfg_pop_tmo = 16'd100;

    // Abort during COLLECT with start in the same cycle, then a clean run.
    pulse_start(32'd3);
    wait_go(40);
    tick(); tick();
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    @(negedge axi_clk);
    check("t6_go",    {63'd0, lm_go},    64'd0);
    check("t6_clear", {63'd0, lm_clear}, 64'd0);
    check("t6_busy",  {63'd0, busy},     64'd0);
    check("t6_done",  {63'd0, done},     64'd0);
    check("t6_lat",   {32'd0, lm_lat_pkt_cnt}, 64'd3);
    repeat (3) tick();
    check("t6_stays_idle", {63'd0, busy}, 64'd0);
    rdy_lat = 1;
    push_rec(16'd1, 16'd4); push_rec(16'd1, 16'd9);
    pulse_start(32'd2);
    wait_go(40);
    tick();
    lm_full = 1'b1;
    wait_done(200);
    tick();
    lm_full = 1'b0;
    check("t6b_cnt", {32'd0, res_cnt}, 64'd2);
    check("t6b_sum", {32'd0, res_sum}, 64'd11);
    check("t6b_min", {48'd0, res_min}, 64'd3);
    check("t6b_max", {48'd0, res_max}, 64'd8);
    check("t6b_err", {61'd0, err},     64'd0);

    // Asynchronous reset in the middle of a drain.
    push_rec(16'd0, 16'd7); push_rec(16'd0, 16'd8); push_rec(16'd0, 16'd9);
    pulse_start(32'd3);
    wait_go(40);
    tick();
    lm_full = 1'b1;
    begin
      int n = 0;
      while (res_cnt == 32'd0 && n < 100) begin @(negedge axi_clk); n++; end
    end
    check("t7_drain_started", {63'd0, (res_cnt != 32'd0)}, 64'd1);
    chk_en = 1'b0;
    #2 axi_rstn = 1'b0;
    #1;
    check("t7_busy",    {63'd0, busy},     64'd0);
    check("t7_pop",     {63'd0, lm_pop},   64'd0);
    check("t7_go",      {63'd0, lm_go},    64'd0);
    check("t7_res_cnt", {32'd0, res_cnt},  64'd0);
    check("t7_res_min", {48'd0, res_min},  64'hFFFF);
    check("t7_lat",     {32'd0, lm_lat_pkt_cnt}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
